// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 16;
  localparam int unsigned MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response and shared-adder signals of the multiply sequencer.
// slave: the sequencer; master: the issuing stage plus the shared adder.
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             add_own;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_err;

  modport slave (
    input  start, op_a, op_b, add_sum, add_err,
    output busy, done, result, add_own, add_a, add_b, add_sub
  );

  modport master (
    output start, op_a, op_b, add_sum, add_err,
    input  busy, done, result, add_own, add_a, add_b, add_sub
  );
endinterface

// File: rtl/lead_one_det.sv
// Highest-set-bit encoder: idx is the index of the top 1 in vec, zero flags vec == 0.
module lead_one_det #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] idx,
  output logic             zero
);

  // Ascending scan: the last set bit seen wins, giving the highest index.
  always_comb begin
    idx  = '0;
    zero = ~|vec;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (vec[i]) idx = CNT_W'(i);
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MSB-first shift-and-add multiplier that borrows the shared
// Execute-stage adder. Produces the low WIDTH bits of A*B (sign-agnostic).
// Optional macro MUL_SEQ_EARLY_EXIT_EN: skip leading zero bits of op_b.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  mul_seq_ctrl_if.slave   bus
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  // Overflow from the shared adder is irrelevant: the product wraps.
  logic unused_add_err;
  assign unused_add_err = bus.add_err;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [CNT_W-1:0] lod_idx;
  logic             lod_zero;

  lead_one_det #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lod (
    .vec  (bus.op_b),
    .idx  (lod_idx),
    .zero (lod_zero)
  );
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Next-state: capture operands on start, one adder pass per RUN cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.op_a;
          acc_d = '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
          if (lod_zero) begin
            b_d     = '0;
            cnt_d   = '0;
            res_d   = '0;
            state_d = DONE;
          end else begin
            // Align the top set bit of the multiplier with the MSB.
            b_d     = bus.op_b << (CNT_W'(WIDTH - 1) - lod_idx);
            cnt_d   = lod_idx;
            state_d = RUN;
          end
`else
          b_d     = bus.op_b;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d = bus.add_sum;
        b_d   = b_q << 1;
        if (cnt_q == '0) begin
          res_d   = bus.add_sum;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; adder operands are forced to zero unless this block owns the adder.
  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.add_own = (state_q == RUN);
    bus.done    = (state_q == DONE);
    bus.result  = res_q;
    bus.add_sub = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    if (state_q == RUN) begin
      bus.add_a = acc_q << 1;
      bus.add_b = b_q[WIDTH-1] ? a_q : '0;
    end
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle multiply sequencer for MUL-class instructions.
- Borrows the Execute stage's shared 16-bit CLA add/sub datapath and iterates MSB-first shift-and-add.
- Produces the low WIDTH bits of A*B, identical for signed and unsigned operands.
- Drives the adder operand ports and an ownership flag; the ALU operand mux selects this block's operands while the flag is high.

Parameters:
- WIDTH, 16, operand/result width; must match the shared adder width.
- CNT_W, $clog2(WIDTH), iteration-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand; captured on accepted start.
- op_b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE; result valid.
- result  output  WIDTH  product low bits; held until the next accepted start.
- add_own  output  1  equals busy; adder borrowed this cycle.
- add_a  output  WIDTH  adder operand A = acc << 1 (combinational).
- add_b  output  WIDTH  adder operand B = b_sh[WIDTH-1] ? a_reg : 0.
- add_sub  output  1  tied 0 (add only).
- add_sum  input  WIDTH  adder Sum, same cycle.
- add_err  input  1  adder overflow flag; ignored, product wraps mod 2^WIDTH.

Behaviour:
- Reset values: state=IDLE; busy, done, add_own = 0; result, acc, a_reg, b_sh, cnt = 0.
- add_a and add_b are 0 whenever state != RUN.
- IDLE, start=1: a_reg<=op_a; b_sh<=op_b; acc<=0; cnt<=WIDTH-1; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - acc<=add_sum; b_sh<=b_sh<<1.
  - If cnt==0, go to DONE and result<=add_sum; else cnt<=cnt-1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- Latency:
  - Start sampled at edge k; RUN spans WIDTH cycles.
  - done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
  - Back-to-back throughput is one op per WIDTH+2 cycles.
- Arithmetic: all shifts are logical; bits shifted out of acc are discarded; add_err never alters state or result.
- Operands of 0 follow the normal path; result = 0 after full latency.
- op_a/op_b may change after the accepted start without effect.
- rst asserted mid-RUN: immediate return to IDLE, all outputs 0, previous result cleared.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- With the macro, on an accepted start:
  - op_b==0: go directly to DONE with result<=0; done appears the cycle after the start cycle.
  - Otherwise: b_sh<=op_b << (WIDTH-1-m) and cnt<=m, where m is the index of the highest set bit of op_b. RUN lasts m+1 cycles.
- Without the macro: fixed WIDTH-cycle RUN for every operand, as above.

Decomposition:
- Shared package mul_pkg holds:
  - enum mul_state_t {IDLE, RUN, DONE}, 2 bits.
  - MUL_WIDTH=16 and MUL_CNT_W=4 constants.
- One sub-module, lead_one_det: combinational WIDTH-bit highest-set-bit encoder (index output, zero flag). Instantiated only under MUL_SEQ_EARLY_EXIT_EN.
- The adder stays external; this block never instantiates it.

Test Plan:
- op_a=3, op_b=5, start 1 cycle:
  - busy for 16 cycles; done on cycle 17; result=0x000F.
  - add_own high exactly 16 cycles.
- op_a=0xFFFD (-3), op_b=7 -> result=0xFFEB (-21); add_err pulses ignored.
- op_a=0x0100, op_b=0x0100 -> result=0x0000 (wrap); op_a=0xFFFF, op_b=0xFFFF -> result=0x0001.
- start held high through RUN with new operands -> only the first op is computed; next accepted start is the cycle after done.
- rst pulsed at RUN cycle 8 of 3*5 -> outputs 0 asynchronously; a following start of 4*4 gives result=0x0010 with full latency.
- MUL_SEQ_EARLY_EXIT_EN defined:
  - op_b=1 -> done 2 cycles after start, result=op_a.
  - op_b=0 -> done 1 cycle after start, result=0.
  - op_b=0x8000 -> done on cycle 17.
